// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs one integer op at a time on the shared ripple ALU
// slice array. Each op is one or more single-cycle passes. XOR and SLL are
// built from several passes, and SLT/SLTU are taken from a subtract pass.
//
// state  | meaning
// IDLE   | waiting for start, array controls held at zero
// RUN    | one array pass per cycle, r_k counts passes
// DONE   | done pulse, result valid, controls zero
module alu_op_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic             o_alu_or,
  output logic             o_alu_inv_a,
  output logic             o_alu_inv_b,
  output logic             o_alu_cin,
  output logic             o_alu_flood,
  input  logic [WIDTH-1:0] i_alu_c,
  input  logic             i_alu_cout
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_SLTU = 3'd6;
  localparam logic [2:0] OP_SLL  = 3'd7;

  // Pass encodings, {or, inv_a, inv_b, cin, flood}
  localparam logic [4:0] PASS_ADD = 5'b00000;
  localparam logic [4:0] PASS_SUB = 5'b00110;
  localparam logic [4:0] PASS_OR  = 5'b10000;
  localparam logic [4:0] PASS_AND = 5'b11101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_op;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_t;
  logic [WIDTH-1:0]  r_u;
  logic [SW-1:0]     r_k;
  logic [WIDTH-1:0]  r_result;
  logic [SW-1:0]     w_npass;
  logic              w_last;
  logic [4:0]        w_ctrl;
  logic              w_ovf;
  logic [WIDTH-1:0]  w_pass_result;
  logic              w_sll_zero;

  assign w_sll_zero = (i_op == OP_SLL) && (i_b[SW-1:0] == '0);

  // Next state, pass decode and array controls; controls come only from registers
  always_comb begin
    w_state_nxt = r_state;
    w_ctrl      = 5'b00000;
    o_alu_a     = '0;
    o_alu_b     = '0;
    case (r_op)
      OP_XOR:  w_npass = SW'(3);
      OP_SLL:  w_npass = r_b[SW-1:0];
      default: w_npass = SW'(1);
    endcase
    w_last = (r_k == w_npass - SW'(1));
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = w_sll_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        o_alu_a = r_a;
        o_alu_b = r_b;
        case (r_op)
          OP_ADD:  w_ctrl = PASS_ADD;
          OP_AND:  w_ctrl = PASS_AND;
          OP_OR:   w_ctrl = PASS_OR;
          OP_XOR: begin
            if (r_k == SW'(0))      w_ctrl = PASS_OR;
            else if (r_k == SW'(1)) w_ctrl = PASS_AND;
            else begin
              w_ctrl  = PASS_SUB;
              o_alu_a = r_t;
              o_alu_b = r_u;
            end
          end
          OP_SLL: begin
            w_ctrl  = PASS_ADD;
            o_alu_a = r_t;
            o_alu_b = r_t;
          end
          default: w_ctrl = PASS_SUB;
        endcase
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    {o_alu_or, o_alu_inv_a, o_alu_inv_b, o_alu_cin, o_alu_flood} = w_ctrl;
  end

  // Final-pass result: comparisons reduce the subtract pass to one bit
  always_comb begin
    w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (i_alu_c[WIDTH-1] != r_a[WIDTH-1]);
    case (r_op)
      OP_SLT:  w_pass_result = {{(WIDTH-1){1'b0}}, i_alu_c[WIDTH-1] ^ w_ovf};
      OP_SLTU: w_pass_result = {{(WIDTH-1){1'b0}}, ~i_alu_cout};
      default: w_pass_result = i_alu_c;
    endcase
  end

  // State register plus operand latch, pass counter and intermediate capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= 3'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_t      <= '0;
      r_u      <= '0;
      r_k      <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op <= i_op;
            r_a  <= i_a;
            r_b  <= i_b;
            r_t  <= i_a;
            r_k  <= '0;
            if (w_sll_zero) r_result <= i_a;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_result <= w_pass_result;
            r_k      <= '0;
          end else begin
            r_k <= r_k + SW'(1);
          end
          if (r_op == OP_SLL) r_t <= i_alu_c;
          if (r_op == OP_XOR && r_k == SW'(0)) r_t <= i_alu_c;
          if (r_op == OP_XOR && r_k == SW'(1)) r_u <= i_alu_c;
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = (r_state == S_DONE);
  assign o_result = r_result;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle controller that executes one integer ALU operation at a time on the shared 32-bit ripple ALU slice array. It latches the operands and the op code on `start`, then drives the array's control lines (`or`, `inv_a`, `inv_b`, `cin`, `flood`) for one or more single-cycle passes, and returns a registered result with a one-cycle `done` pulse. XOR and SLL are not native array functions, so the sequencer builds them from several passes. SLT and SLTU are derived from a subtract pass.

## Interface
- `WIDTH`, 32, datapath width. The shift amount is `$clog2(WIDTH)` bits.
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, synchronous and active-high.
- `start`  in  1  request. Accepted only when `busy`=0.
- `op`  in  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL.
- `a`, `b`  in  WIDTH  operands. SLL uses `b[4:0]` as the shift amount.
- `busy`  out  1  high while state ≠ IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid from that cycle on.
- `result`  out  WIDTH  registered result. Held until the next `done`.
- `alu_a`, `alu_b`  out  WIDTH  array operands.
- `alu_or`, `alu_inv_a`, `alu_inv_b`, `alu_cin`, `alu_flood`  out  1  array controls.
- `alu_c`  in  WIDTH  array output. Combinational from the `alu_*` outputs, same cycle.
- `alu_cout`  in  1  array carry out.

## Operation
- Array model per bit i:
  - `A0 = a^inv_a`, `B0 = b^inv_b`.
  - `P = or ? A0|B0 : A0^B0`.
  - `c[i+1] = P&c[i] | A0&B0&~or`, with `c[0]=cin` and `cout=c[WIDTH]`.
  - `out[i] = P^(c[i]|flood)`.
- Pass encodings as {or, inv_a, inv_b, cin, flood}:
  - ADD {0,0,0,0,0}
  - SUB {0,0,1,1,0}
  - OR {1,0,0,0,0}
  - AND {1,1,1,0,1}
- States:
  - IDLE: accepts `start`.
  - RUN: one array pass per cycle, pass counter `k`.
  - DONE: `done`=1 for one cycle, then back to IDLE.
- On accepting `start`, latch `op`, `a`, `b`, set `T=a` and `k=0`, go to RUN. The exception is SLL with shamt 0, which goes straight to DONE with `result=a`.
- Pass programs; `alu_c` is captured at the end of each pass:
  - ADD, SUB, AND, OR: one pass on (a, b). Result is `alu_c`.
  - XOR, three passes:
    - k0: OR(a, b) → T.
    - k1: AND(a, b) → U.
    - k2: SUB(T, U) → result.
  - SLT and SLTU: one SUB(a, b) pass.
    - SLTU result = `{0…, ~alu_cout}`.
    - SLT result = `{0…, alu_c[31] ^ ovf}`, where `ovf = (a[31]≠b[31]) & (alu_c[31]≠a[31])`.
  - SLL: shamt passes of ADD(T, T) → T. The final T is the result. Shamt range is 1–31.
- Control outputs are decoded from registered state only, with no combinational path from `start`, `op`, `a` or `b`. In IDLE and DONE, all `alu_*` outputs are 0.
- `start` while `busy`=1 (RUN or DONE) is ignored. Operand and op changes while busy have no effect.
- Unused op codes: none, since all 8 are defined.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `done`=0, `result`=0.
  - T, U, k = 0.
  - all `alu_*` outputs = 0.
- Reset mid-operation abandons the op. IDLE holds from the next cycle, no `done` is issued, and `result` is cleared.
- `rst` wins over a simultaneous `start`.
- Latency with N passes and `start` sampled at edge E:
  - RUN spans cycles E+1 … E+N.
  - `done` is high in cycle E+N+1.
  - `busy` rises in cycle E+1 and falls after the `done` cycle.
- Pass counts and resulting `done` cycle:
  - ADD, SUB, AND, OR, SLT, SLTU: N=1, `done` at E+2.
  - XOR: N=3, `done` at E+4.
  - SLL: N=shamt. Shamt 0 gives `done` at E+1; shamt 31 gives `done` at E+32.
- Back-to-back: the earliest next `start` is accepted in the cycle after `done`, at the IDLE edge.
- Arithmetic is modulo 2^WIDTH. Carries beyond bit 31 are dropped, except that SLTU uses `alu_cout`.

## Test plan
- ADD `a`=0x7FFFFFFF, `b`=1 → `result` 0x80000000, `done` at E+2, `busy` high exactly for E+1..E+2.
- AND `a`=0xFFFF0000, `b`=0x0F0F0F0F → 0x0F0F0000. During the pass, check `alu_flood`=1, `alu_or`=1, `alu_inv_a`=`alu_inv_b`=1.
- XOR `a`=0xF0F01234, `b`=0xFF00FFFF → 0x0FF0EDCB at E+4. Pass controls must follow OR → AND → SUB in that order.
- Comparisons:
  - SLT (0xFFFFFFFF, 1) → 1.
  - SLTU (0xFFFFFFFF, 1) → 0.
  - SLT (0x80000000, 1) → 1, the overflow case.
  - SLT (0x7FFFFFFF, 0xFFFFFFFF) → 0.
- SLL:
  - `a`=1, `b`=31 → 0x80000000 at E+32.
  - `a`=0x12345678, `b`=0x20 (shamt 0) → 0x12345678 at E+1.
- Pulse `start` with op=ADD during XOR RUN → ignored, and the XOR result is unchanged. Assert `rst` at E+2 of a new XOR → `busy` is 0 in the next cycle, `done` never pulses, and all `alu_*` outputs are 0.
